// File: rtl/mdl_bubble_heater_emu_pkg.sv
// Shared constants, state encoding and temperature arithmetic for the bubble
// cassette thermal-plant emulator.
package mdl_bubble_heater_emu_pkg;

    typedef enum logic {
        ST_COLD  = 1'b0,
        ST_READY = 1'b1
    } heater_state_t;

    localparam int TEMP_W = 8;

    localparam int DEF_PRESCALE     = 4000;
    localparam int DEF_TEMP_AMBIENT = 20;
    localparam int DEF_TEMP_MAX     = 100;
    localparam int DEF_T_LO         = 40;
    localparam int DEF_T_HI         = 45;
    localparam int DEF_HEAT_STEP    = 1;
    localparam int DEF_COOL_STEP    = 1;
    localparam int DEF_SETTLE_TICKS = 8;

    // One thermal tick of the plant, computed one bit wider so it can never wrap.
    function automatic logic [TEMP_W-1:0] temp_next(
        input logic [TEMP_W-1:0] cur,
        input logic              heat,
        input logic [TEMP_W-1:0] step_up,
        input logic [TEMP_W-1:0] step_dn,
        input logic [TEMP_W-1:0] floor_t,
        input logic [TEMP_W-1:0] ceil_t
    );
        logic [TEMP_W:0] wide;
        if (heat) begin
            wide = {1'b0, cur} + {1'b0, step_up};
            if (wide > {1'b0, ceil_t}) begin
                wide = {1'b0, ceil_t};
            end
        end else begin
            if ({1'b0, cur} < ({1'b0, floor_t} + {1'b0, step_dn})) begin
                wide = {1'b0, floor_t};
            end else begin
                wide = {1'b0, cur} - {1'b0, step_dn};
            end
        end
        return wide[TEMP_W-1:0];
    endfunction

endpackage

// File: rtl/mdl_bubble_heater_emu_if.sv
// Heater-enable / temperature-low link between the controller core (master)
// and the cassette thermal-plant emulator (slave).
interface mdl_bubble_heater_emu_if;
    import mdl_bubble_heater_emu_pkg::*;

    // Level handshake: the master holds i_HEATEN_n low to request heat; the
    // slave answers on o_TEMPLO_n (low = too cold), changing it only on a
    // registered thermal tick or preload. i_CLK4M_PCEN_n qualifies every cycle.
    logic              i_CLK4M_PCEN_n;
    logic              i_HEATEN_n;
    logic              i_PRELOAD;
    logic              o_TEMPLO_n;
    logic [TEMP_W-1:0] o_TEMP;
    logic              o_HEATING;
    logic              o_READY;

    modport master (
        output i_CLK4M_PCEN_n,
        output i_HEATEN_n,
        output i_PRELOAD,
        input  o_TEMPLO_n,
        input  o_TEMP,
        input  o_HEATING,
        input  o_READY
    );

    modport slave (
        input  i_CLK4M_PCEN_n,
        input  i_HEATEN_n,
        input  i_PRELOAD,
        output o_TEMPLO_n,
        output o_TEMP,
        output o_HEATING,
        output o_READY
    );

endinterface

// File: rtl/mdl_heater_prescaler.sv
// Enable-gated modulo-PRESCALE counter producing the 1 ms thermal tick.
module mdl_heater_prescaler #(
    parameter int PRESCALE = 4000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mdl_bubble_heater_emu.sv
// Bubble cassette thermal plant: filters the heater request, integrates a
// modelled temperature and drives the temperature-low sensor with hysteresis.
module mdl_bubble_heater_emu
    import mdl_bubble_heater_emu_pkg::*;
#(
    parameter int PRESCALE     = DEF_PRESCALE,
    parameter int TEMP_AMBIENT = DEF_TEMP_AMBIENT,
    parameter int TEMP_MAX     = DEF_TEMP_MAX,
    parameter int T_LO         = DEF_T_LO,
    parameter int T_HI         = DEF_T_HI,
    parameter int HEAT_STEP    = DEF_HEAT_STEP,
    parameter int COOL_STEP    = DEF_COOL_STEP,
    parameter int SETTLE_TICKS = DEF_SETTLE_TICKS
) (
    input  logic                     i_MCLK,
    input  logic                     i_RST,
    mdl_bubble_heater_emu_if.slave   bus
);

    localparam int DWELL_W = $clog2(SETTLE_TICKS + 1);

    localparam logic [TEMP_W-1:0]  AMB_V   = TEMP_W'(TEMP_AMBIENT);
    localparam logic [TEMP_W-1:0]  MAX_V   = TEMP_W'(TEMP_MAX);
    localparam logic [TEMP_W-1:0]  LO_V    = TEMP_W'(T_LO);
    localparam logic [TEMP_W-1:0]  HI_V    = TEMP_W'(T_HI);
    localparam logic [TEMP_W-1:0]  UP_V    = TEMP_W'(HEAT_STEP);
    localparam logic [TEMP_W-1:0]  DN_V    = TEMP_W'(COOL_STEP);
    localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(SETTLE_TICKS - 1);

    logic               en;
    logic               preload;
    logic               tick;
    logic [1:0]         heat_sr;
    logic               heat_on;

    heater_state_t      state_q, state_d;
    logic [TEMP_W-1:0]  temp_q, temp_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;

    assign en      = ~bus.i_CLK4M_PCEN_n;
    assign preload = bus.i_PRELOAD;

    mdl_heater_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk  (i_MCLK),
        .rst  (i_RST),
        .en   (en),
        .clr  (preload),
        .tick (tick)
    );

    // Two-stage shift of the raw request: a single enabled low cycle never
    // leaves both stages low, so it cannot turn the heater on.
    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            heat_sr <= 2'b11;
        end else if (en) begin
            heat_sr <= {heat_sr[0], bus.i_HEATEN_n};
        end
    end

    assign heat_on = (heat_sr == 2'b00);

    always_ff @(posedge i_MCLK) begin
        if (i_RST) begin
            state_q <= ST_COLD;
            temp_q  <= AMB_V;
            dwell_q <= '0;
        end else begin
            state_q <= state_d;
            temp_q  <= temp_d;
            dwell_q <= dwell_d;
        end
    end

    // The FSM judges the temperature held before this tick's integration step.
    always_comb begin
        state_d = state_q;
        temp_d  = temp_q;
        dwell_d = dwell_q;
        if (preload) begin
            state_d = ST_READY;
            temp_d  = HI_V;
            dwell_d = '0;
        end else if (tick) begin
            temp_d = temp_next(temp_q, heat_on, UP_V, DN_V, AMB_V, MAX_V);
            case (state_q)
                ST_COLD: begin
                    if (temp_q >= HI_V) begin
                        if (dwell_q == DWELL_LAST) begin
                            state_d = ST_READY;
                            dwell_d = '0;
                        end else begin
                            dwell_d = dwell_q + 1'b1;
                        end
                    end else begin
                        dwell_d = '0;
                    end
                end
                ST_READY: begin
                    if (temp_q < LO_V) begin
                        state_d = ST_COLD;
                        dwell_d = '0;
                    end
                end
                default: begin
                    state_d = ST_COLD;
                    dwell_d = '0;
                end
            endcase
        end
    end

    // The sensor line and ready flag are the registered state itself.
    assign bus.o_TEMPLO_n = (state_q == ST_READY);
    assign bus.o_READY    = (state_q == ST_READY);
    assign bus.o_TEMP     = temp_q;
    assign bus.o_HEATING  = heat_on;

endmodule

// File: tb/tb_mdl_bubble_heater_emu.sv
// Directed bench for the bubble cassette thermal-plant emulator at PRESCALE=4.
module tb_mdl_bubble_heater_emu;

    localparam int PRESCALE = 4;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mdl_bubble_heater_emu_if bus ();

    mdl_bubble_heater_emu #(
        .PRESCALE (PRESCALE)
    ) dut (
        .i_MCLK (clk),
        .i_RST  (rst),
        .bus    (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // One enabled cycle followed by one disabled cycle.
    task automatic run_en(input int n);
        for (int i = 0; i < n; i++) begin
            bus.i_CLK4M_PCEN_n = 1'b0;
            @(posedge clk);
            #1;
            bus.i_CLK4M_PCEN_n = 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic one_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        bus.i_CLK4M_PCEN_n = 1'b1;
        bus.i_HEATEN_n     = 1'b1;
        bus.i_PRELOAD      = 1'b0;
        one_edge();
        rst = 1'b0;

        check("rst_temp", bus.o_TEMP, 20);
        check("rst_templo", bus.o_TEMPLO_n, 0);
        check("rst_heating", bus.o_HEATING, 0);
        check("rst_ready", bus.o_READY, 0);

        // Cold heat-up: 25 ticks to 45, sensor releases on tick 33.
        bus.i_HEATEN_n = 1'b0;
        run_en(100);
        check("heat_t45", bus.o_TEMP, 45);
        check("heat_templo_25", bus.o_TEMPLO_n, 0);
        check("heat_on", bus.o_HEATING, 1);
        run_en(31);
        check("heat_t52", bus.o_TEMP, 52);
        check("heat_templo_32", bus.o_TEMPLO_n, 0);
        run_en(1);
        check("heat_templo_33", bus.o_TEMPLO_n, 1);
        check("heat_ready_33", bus.o_READY, 1);
        check("heat_t53", bus.o_TEMP, 53);

        // Reset while heating returns everything to reset values on that edge.
        rst = 1'b1;
        one_edge();
        check("midrst_temp", bus.o_TEMP, 20);
        check("midrst_templo", bus.o_TEMPLO_n, 0);
        check("midrst_heating", bus.o_HEATING, 0);
        check("midrst_ready", bus.o_READY, 0);
        rst = 1'b0;
        bus.i_HEATEN_n = 1'b1;

        // Glitch rejection: one enabled low cycle on the heater request.
        bus.i_HEATEN_n = 1'b0;
        run_en(1);
        bus.i_HEATEN_n = 1'b1;
        check("glitch_heat_a", bus.o_HEATING, 0);
        run_en(1);
        check("glitch_heat_b", bus.o_HEATING, 0);
        run_en(40);
        check("glitch_temp", bus.o_TEMP, 20);
        check("glitch_heat_c", bus.o_HEATING, 0);

        // Preload while disabled, then cool down through the hysteresis band.
        bus.i_PRELOAD = 1'b1;
        one_edge();
        bus.i_PRELOAD = 1'b0;
        check("pre_temp", bus.o_TEMP, 45);
        check("pre_templo", bus.o_TEMPLO_n, 1);
        check("pre_ready", bus.o_READY, 1);
        run_en(24);
        check("cool_t39", bus.o_TEMP, 39);
        check("cool_templo_6", bus.o_TEMPLO_n, 1);
        run_en(3);
        check("cool_templo_6b", bus.o_TEMPLO_n, 1);
        run_en(1);
        check("cool_templo_7", bus.o_TEMPLO_n, 0);
        check("cool_ready_7", bus.o_READY, 0);
        check("cool_t38", bus.o_TEMP, 38);

        // Dwell interruption: build dwell to 5 around 45/46, then sample 44.
        bus.i_HEATEN_n = 1'b0;
        run_en(28);
        check("dwell_t45", bus.o_TEMP, 45);
        run_en(4);
        bus.i_HEATEN_n = 1'b1;
        run_en(4);
        bus.i_HEATEN_n = 1'b0;
        run_en(4);
        check("dwell_t46", bus.o_TEMP, 46);
        bus.i_HEATEN_n = 1'b1;
        run_en(8);
        check("dwell_t44", bus.o_TEMP, 44);
        check("dwell_templo_5", bus.o_TEMPLO_n, 0);
        run_en(4);
        check("dwell_t43", bus.o_TEMP, 43);
        bus.i_HEATEN_n = 1'b0;
        run_en(8);
        check("reheat_t45", bus.o_TEMP, 45);
        run_en(28);
        check("reheat_t52", bus.o_TEMP, 52);
        check("reheat_templo_7", bus.o_TEMPLO_n, 0);
        run_en(4);
        check("reheat_templo_8", bus.o_TEMPLO_n, 1);
        check("reheat_t53", bus.o_TEMP, 53);

        // Preload beats a coincident tick and restarts the prescaler.
        run_en(3);
        check("prio_pre_t53", bus.o_TEMP, 53);
        bus.i_PRELOAD      = 1'b1;
        bus.i_CLK4M_PCEN_n = 1'b0;
        one_edge();
        bus.i_PRELOAD      = 1'b0;
        bus.i_CLK4M_PCEN_n = 1'b1;
        check("prio_temp", bus.o_TEMP, 45);
        run_en(3);
        check("prio_hold", bus.o_TEMP, 45);
        run_en(1);
        check("prio_next_tick", bus.o_TEMP, 46);

        // Reset wins over preload.
        bus.i_PRELOAD = 1'b1;
        rst = 1'b1;
        one_edge();
        bus.i_PRELOAD = 1'b0;
        rst = 1'b0;
        check("rstpre_temp", bus.o_TEMP, 20);
        check("rstpre_templo", bus.o_TEMPLO_n, 0);
        check("rstpre_ready", bus.o_READY, 0);

        // Saturation at both ends over 200 ticks each.
        bus.i_HEATEN_n = 1'b0;
        run_en(200 * PRESCALE);
        check("sat_hi_temp", bus.o_TEMP, 100);
        check("sat_hi_heating", bus.o_HEATING, 1);
        check("sat_hi_templo", bus.o_TEMPLO_n, 1);
        bus.i_HEATEN_n = 1'b1;
        run_en(200 * PRESCALE);
        check("sat_lo_temp", bus.o_TEMP, 20);
        check("sat_lo_heating", bus.o_HEATING, 0);
        check("sat_lo_templo", bus.o_TEMPLO_n, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
